phys_reg_ready_table_mw: RTL and testbench

Parametrised multi-way successor of the single-dispatch phys reg ready table in dispatch_unit. It tracks a ready bit per physical register and serves NUM_DISPATCH dispatch ways, each with 2 source reads and 1 dest clear. It takes NUM_COMPLETE complete-bus sets, and forwards same-cycle writes and older-way dest clears to every read. It also keeps a registered busy-register count and a registered error pulse for dispatch stall heuristics and debug.

---
 rtl/phys_reg_ready_table_mw.sv | 178 +++++++++++++++++
 tb/tb_phys_reg_ready_table_mw.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_ready_table_mw.sv
// phys_reg_ready_table_mw: multi-way physical register ready table with forwarding, busy count and error pulse; sticky error log under PRRT_ERROR_LOG_EN
module phys_reg_ready_table_mw #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_DISPATCH = 2,
  parameter int NUM_COMPLETE = 3,
  localparam int TW = $clog2(NUM_PHYS_REGS),
  localparam int CW = $clog2(NUM_PHYS_REGS + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       DUT_error,
  input  logic [NUM_DISPATCH*TW-1:0] dispatch_source_0_phys_reg_tag,
  output logic [NUM_DISPATCH-1:0]    dispatch_source_0_ready,
  input  logic [NUM_DISPATCH*TW-1:0] dispatch_source_1_phys_reg_tag,
  output logic [NUM_DISPATCH-1:0]    dispatch_source_1_ready,
  input  logic [NUM_DISPATCH-1:0]    dispatch_dest_write,
  input  logic [NUM_DISPATCH*TW-1:0] dispatch_dest_phys_reg_tag,
  input  logic [NUM_COMPLETE-1:0]    complete_bus_valid,
  input  logic [NUM_COMPLETE*TW-1:0] complete_bus_dest_phys_reg_tag,
  output logic [CW-1:0]              busy_count,
  input  logic                       error_clear,
  output logic [2:0]                 error_status,
  output logic [TW-1:0]              error_first_tag
);
  localparam int NW = NUM_DISPATCH + NUM_COMPLETE;
  localparam logic [NUM_PHYS_REGS-1:0] RESET_READY = {NUM_PHYS_REGS{1'b1}} >> (NUM_PHYS_REGS - NUM_ARCH_REGS);

  function automatic logic in_range(input logic [TW-1:0] t);
    return {1'b0, t} < (TW+1)'(NUM_PHYS_REGS);
  endfunction

  logic [NUM_PHYS_REGS-1:0] ready_q, ready_d, set_v, clr_v, clr_acc;
  logic [NUM_PHYS_REGS-1:0] way_clr [NUM_DISPATCH];
  logic [NUM_PHYS_REGS-1:0] vis [NUM_DISPATCH];
  logic [NW-1:0]            wr_en;
  logic [TW-1:0]            wr_tag [NW];
  logic [CW-1:0]            busy_count_q, busy_count_d;
  logic                     dut_error_q, dut_error_d;
  logic                     multi_writer, write_tag0, read_tag_oob;
  logic [TW-1:0]            viol_tag;

  // flatten dispatch dest clears and complete sets into one writer list
  always_comb begin
    for (int w = 0; w < NUM_DISPATCH; w++) begin
      wr_en[w] = dispatch_dest_write[w];
      wr_tag[w] = dispatch_dest_phys_reg_tag[w*TW +: TW];
    end
    for (int c = 0; c < NUM_COMPLETE; c++) begin
      wr_en[NUM_DISPATCH+c] = complete_bus_valid[c];
      wr_tag[NUM_DISPATCH+c] = complete_bus_dest_phys_reg_tag[c*TW +: TW];
    end
  end

  // decode per-tag sets and per-way clears; tag 0 and out-of-range tags never match
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int w = 0; w < NUM_DISPATCH; w++) way_clr[w] = '0;
    for (int t = 1; t < NUM_PHYS_REGS; t++) begin
      for (int c = 0; c < NUM_COMPLETE; c++)
        if (complete_bus_valid[c] && complete_bus_dest_phys_reg_tag[c*TW +: TW] == TW'(t)) set_v[t] = 1'b1;
      for (int w = 0; w < NUM_DISPATCH; w++)
        if (dispatch_dest_write[w] && dispatch_dest_phys_reg_tag[w*TW +: TW] == TW'(t)) begin
          way_clr[w][t] = 1'b1;
          clr_v[t] = 1'b1;
        end
    end
  end

  // next table state: clears beat sets, tag 0 pinned ready
  always_comb begin
    ready_d = (ready_q | set_v) & ~clr_v;
    ready_d[0] = 1'b1;
  end

  // per-way view: registered state plus this cycle's sets, minus clears from older ways only
  always_comb begin
    clr_acc = '0;
    for (int w = 0; w < NUM_DISPATCH; w++) begin
      vis[w] = (ready_q | set_v) & ~clr_acc;
      vis[w][0] = 1'b1;
      clr_acc = clr_acc | way_clr[w];
    end
  end

  // source ready lookups; out-of-range tags read not-ready
  always_comb begin
    for (int w = 0; w < NUM_DISPATCH; w++) begin
      dispatch_source_0_ready[w] = in_range(dispatch_source_0_phys_reg_tag[w*TW +: TW]) && vis[w][dispatch_source_0_phys_reg_tag[w*TW +: TW]];
      dispatch_source_1_ready[w] = in_range(dispatch_source_1_phys_reg_tag[w*TW +: TW]) && vis[w][dispatch_source_1_phys_reg_tag[w*TW +: TW]];
    end
  end

  // violation detection and lowest offending tag
  always_comb begin
    multi_writer = 1'b0;
    write_tag0 = 1'b0;
    read_tag_oob = 1'b0;
    viol_tag = '1;
    for (int i = 0; i < NW; i++) begin
      if (wr_en[i] && (wr_tag[i] == '0 || !in_range(wr_tag[i]))) begin
        write_tag0 = 1'b1;
        viol_tag = (wr_tag[i] < viol_tag) ? wr_tag[i] : viol_tag;
      end
      for (int j = i + 1; j < NW; j++)
        if (wr_en[i] && wr_en[j] && wr_tag[i] == wr_tag[j]) begin
          multi_writer = 1'b1;
          viol_tag = (wr_tag[i] < viol_tag) ? wr_tag[i] : viol_tag;
        end
    end
    for (int w = 0; w < NUM_DISPATCH; w++) begin
      if (!in_range(dispatch_source_0_phys_reg_tag[w*TW +: TW])) begin
        read_tag_oob = 1'b1;
        viol_tag = (dispatch_source_0_phys_reg_tag[w*TW +: TW] < viol_tag) ? dispatch_source_0_phys_reg_tag[w*TW +: TW] : viol_tag;
      end
      if (!in_range(dispatch_source_1_phys_reg_tag[w*TW +: TW])) begin
        read_tag_oob = 1'b1;
        viol_tag = (dispatch_source_1_phys_reg_tag[w*TW +: TW] < viol_tag) ? dispatch_source_1_phys_reg_tag[w*TW +: TW] : viol_tag;
      end
    end
  end

  // busy count from the registered table and error pulse request
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NUM_PHYS_REGS; i++) busy_count_d = busy_count_d + CW'(!ready_q[i]);
    dut_error_d = multi_writer | write_tag0 | read_tag_oob;
  end

  // table, busy count and error pulse registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q <= RESET_READY;
      busy_count_q <= CW'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      dut_error_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_count_q <= busy_count_d;
      dut_error_q <= dut_error_d;
    end
  end

  assign busy_count = busy_count_q;
  assign DUT_error = dut_error_q;

`ifdef PRRT_ERROR_LOG_EN
  logic [2:0]    error_status_q, error_status_d;
  logic [TW-1:0] error_first_tag_q, error_first_tag_d;
  logic [2:0]    viol;

  // sticky log: a violation in the clear cycle survives, first tag captured only when the log is empty
  always_comb begin
    viol = {multi_writer, write_tag0, read_tag_oob};
    error_status_d = (error_clear ? 3'b0 : error_status_q) | viol;
    error_first_tag_d = (|viol && (error_clear || error_status_q == 3'b0)) ? viol_tag : error_clear ? '0 : error_first_tag_q;
  end

  // error log registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      error_status_q <= 3'b0;
      error_first_tag_q <= '0;
    end else begin
      error_status_q <= error_status_d;
      error_first_tag_q <= error_first_tag_d;
    end
  end

  assign error_status = error_status_q;
  assign error_first_tag = error_first_tag_q;
`else
  logic unused_log;
  assign unused_log = ^{error_clear, viol_tag};
  assign error_status = 3'b0;
  assign error_first_tag = '0;
`endif
endmodule

// File: tb/tb_phys_reg_ready_table_mw.sv
// tb_phys_reg_ready_table_mw: directed checks of ready table forwarding, busy count, error pulse and log
module tb_phys_reg_ready_table_mw;
  localparam int TW = 6;
  localparam int CW = 7;
  localparam int ND = 2;
  localparam int NC = 3;
`ifdef PRRT_ERROR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic DUT_error;
  logic [ND*TW-1:0] s0_tag, s1_tag, d_tag;
  logic [ND-1:0] s0_rdy, s1_rdy, dw;
  logic [NC-1:0] cb_v;
  logic [NC*TW-1:0] cb_tag;
  logic [CW-1:0] busy;
  logic error_clear;
  logic [2:0] error_status;
  logic [TW-1:0] error_first_tag;
  int checks = 0;
  int passed = 0;

  phys_reg_ready_table_mw dut (
    .CLK(CLK), .RST(RST), .DUT_error(DUT_error),
    .dispatch_source_0_phys_reg_tag(s0_tag), .dispatch_source_0_ready(s0_rdy),
    .dispatch_source_1_phys_reg_tag(s1_tag), .dispatch_source_1_ready(s1_rdy),
    .dispatch_dest_write(dw), .dispatch_dest_phys_reg_tag(d_tag),
    .complete_bus_valid(cb_v), .complete_bus_dest_phys_reg_tag(cb_tag),
    .busy_count(busy), .error_clear(error_clear),
    .error_status(error_status), .error_first_tag(error_first_tag)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    s0_tag = '0; s1_tag = '0; d_tag = '0; dw = '0; cb_v = '0; cb_tag = '0;
  endtask

  task automatic rd(input int w, input int s, input int t);
    if (s == 0) s0_tag[w*TW +: TW] = TW'(t);
    else s1_tag[w*TW +: TW] = TW'(t);
  endtask

  task automatic dwr(input int w, input int t);
    dw[w] = 1'b1;
    d_tag[w*TW +: TW] = TW'(t);
  endtask

  task automatic cb(input int b, input int t);
    cb_v[b] = 1'b1;
    cb_tag[b*TW +: TW] = TW'(t);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    idle();
    error_clear = 1'b0;
    #12;
    check("rst_busy", busy, 32);
    check("rst_err", DUT_error, 0);
    check("rst_status", error_status, 0);
    check("rst_first", error_first_tag, 0);
    @(negedge CLK);
    RST = 1'b0;
    rd(0, 0, 5); rd(0, 1, 40); rd(1, 0, 5); rd(1, 1, 40);
    #1;
    check("rd5_w0", s0_rdy[0], 1);
    check("rd40_w0", s1_rdy[0], 0);
    check("rd5_w1", s0_rdy[1], 1);
    check("rd40_w1", s1_rdy[1], 0);
    rd(1, 1, 0);
    #1;
    check("rd0_w1", s1_rdy[1], 1);
    tick();
    check("busy_idle", busy, 32);
    idle(); cb(1, 40); rd(0, 0, 40);
    #1;
    check("fwd_set40", s0_rdy[0], 1);
    tick();
    check("set40_err", DUT_error, 0);
    check("set40_busy_lag", busy, 32);
    idle(); rd(0, 0, 40);
    #1;
    check("reg40", s0_rdy[0], 1);
    tick();
    check("busy31", busy, 31);
    idle(); cb(0, 33); cb(1, 34);
    tick();
    idle(); dwr(0, 33); dwr(1, 34);
    rd(0, 0, 33); rd(1, 1, 33); rd(0, 1, 34); rd(1, 0, 34);
    #1;
    check("w0_own_clr33", s0_rdy[0], 1);
    check("w1_old_clr33", s1_rdy[1], 0);
    check("w0_young_clr34", s1_rdy[0], 1);
    check("w1_own_clr34", s0_rdy[1], 1);
    tick();
    check("clr_err", DUT_error, 0);
    idle(); rd(0, 0, 33); rd(0, 1, 34);
    #1;
    check("reg33", s0_rdy[0], 0);
    check("reg34", s1_rdy[0], 0);
    idle(); cb(0, 50); dwr(1, 50); rd(0, 0, 50); rd(1, 0, 50);
    #1;
    check("w0_rd50", s0_rdy[0], 1);
    check("w1_rd50", s0_rdy[1], 1);
    tick();
    check("multi_err", DUT_error, 1);
    check("multi_status", error_status, LOG ? 4 : 0);
    check("multi_first", error_first_tag, LOG ? 50 : 0);
    idle(); rd(0, 0, 50);
    #1;
    check("reg50", s0_rdy[0], 0);
    tick();
    check("err_pulse_end", DUT_error, 0);
    check("status_sticky", error_status, LOG ? 4 : 0);
    idle(); cb(2, 0); rd(0, 0, 0);
    #1;
    check("tag0_rd", s0_rdy[0], 1);
    tick();
    check("tag0_err", DUT_error, 1);
    check("tag0_status", error_status, LOG ? 6 : 0);
    check("tag0_first", error_first_tag, LOG ? 50 : 0);
    idle(); rd(0, 0, 0);
    #1;
    check("tag0_still_ready", s0_rdy[0], 1);
    error_clear = 1'b1;
    tick();
    check("clr_status", error_status, 0);
    check("clr_first", error_first_tag, 0);
    check("clr_err", DUT_error, 0);
    idle(); cb(0, 45); cb(1, 45);
    tick();
    check("clr_viol_status", error_status, LOG ? 4 : 0);
    check("clr_viol_first", error_first_tag, LOG ? 45 : 0);
    check("clr_viol_err", DUT_error, 1);
    error_clear = 1'b0;
    idle();
    tick();
    tick();
    check("busy30", busy, 30);
    rd(0, 0, 45);
    #1;
    check("reg45", s0_rdy[0], 1);
    for (int k = 0; k < 4; k++) begin
      idle(); cb(0, 32 + 3*k); cb(1, 33 + 3*k); cb(2, 34 + 3*k);
      tick();
    end
    idle(); cb(0, 44); cb(1, 45); cb(2, 46);
    rd(0, 0, 40); rd(0, 1, 32); rd(1, 0, 31); rd(1, 1, 43);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_40", s0_rdy[0], 0);
    check("rst_mid_32", s1_rdy[0], 0);
    check("rst_mid_31", s0_rdy[1], 1);
    check("rst_mid_43", s1_rdy[1], 0);
    check("rst_mid_busy", busy, 32);
    check("rst_mid_err", DUT_error, 0);
    tick();
    check("rst_hold_40", s0_rdy[0], 0);
    check("rst_hold_busy", busy, 32);
    idle();
    @(negedge CLK);
    RST = 1'b0;
    rd(0, 0, 44); rd(1, 0, 45);
    tick();
    check("post_rst_44", s0_rdy[0], 0);
    check("post_rst_45", s0_rdy[1], 0);
    check("post_rst_busy", busy, 32);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
